// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : shared state encoding and default width for serial_adder
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// ============================================================================
// full_adder_cell : one-bit combinational full adder from two half-adder stages
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = a ^ b;
    assign ha0_c = a & b;
    assign s     = ha0_s ^ cin;
    assign ha1_c = ha0_s & cin;
    assign co    = ha0_c | ha1_c;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : bit-serial LSB-first adder, one bit per clock, registered I/O
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_co;
    logic             last_bit;
    logic             accept;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = start && (state != SHIFT);

    full_adder_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (cell_s),
        .co  (cell_co)
    );

    // Cell sum enters at the MSB so the LSB-first result lands right-aligned.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = cell_s;
        end else begin : g_res_wn
            assign res_next = {cell_s, res_sr[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == SHIFT);
            done  <= (state_next == DONE);
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                carry  <= cin;
                cnt    <= '0;
                res_sr <= '0;
            end else if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                carry  <= cell_co;
                cnt    <= cnt + 1'b1;
                res_sr <= res_next;
                // Outputs update only once the final bit is in.
                if (last_bit) begin
                    sum  <= res_next;
                    cout <= cell_co;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : scoreboard bench for serial_adder at WIDTH=8
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W:0] res;
        int         cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    exp_t   sb[$];
    int     total = 0;
    int     passed = 0;
    int     cyc = 0;
    logic [W:0] held = '0;
    int     run = 0;
    logic   prev_done = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic fail_evt(input string nm);
        total++;
        $display("FAIL %s: event did not match expectation at %0t", nm, $time);
    endtask

    // Monitor: pops the scoreboard on each done pulse, checks holding in between.
    always @(negedge clk) begin
        if (rst) begin
            held      = '0;
            run       = 0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("done_width", prev_done, 0);
                check("busy_in_done", busy, 0);
                if (sb.size() == 0) begin
                    fail_evt("unexpected_done");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", {cout, sum}, e.res);
                    check("latency", cyc - e.cyc, W);
                    check("busy_cycles", run, W);
                    held = e.res;
                end
                run = 0;
            end else begin
                check("hold", {cout, sum}, held);
                if (busy) run++;
                else run = 0;
            end
            prev_done = done;
        end
    end

    // Called at 1 time unit after a rising edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                         input logic tc, input logic [W:0] exp, input bit track);
        int guard = 0;
        while (busy === 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) fail_evt("issue_timeout");
        a = ta; b = tb2; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        if (track) sb.push_back('{res: exp, cyc: cyc});
        start = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || busy === 1'b1) && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        #20 rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        issue(8'h0F, 8'h01, 1'b0, 9'h010, 1'b1);
        issue(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
        issue(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1);
        issue(8'h01, 8'h02, 1'b0, 9'h003, 1'b1);
        issue(8'h00, 8'h00, 1'b0, 9'h000, 1'b1);
        issue(8'hA5, 8'h5A, 1'b1, 9'h100, 1'b1);
        drain();

        // Start held through SHIFT while operand A changes
        a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{res: 9'h047, cyc: cyc});
        a = 8'h55;
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b0;
        drain();

        // Reset mid-operation aborts with no done pulse
        issue(8'h33, 8'h44, 1'b0, 9'h077, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(8'h80, 8'h80, 1'b1, 9'h101, 1'b1);
        drain();

        // Back-to-back: second start lands in the DONE cycle
        issue(8'h10, 8'h20, 1'b0, 9'h030, 1'b1);
        issue(8'h01, 8'h02, 1'b0, 9'h003, 1'b1);
        drain();

        // Random operands with random gaps
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            issue(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc}, 1'b1);
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range is 1 to 64.
REQ-002 clk  input  1  single clock; all state is updated on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge.
REQ-005 a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse when sum and cout become valid.
REQ-010 sum  output  WIDTH  result bits; held stable until the next accepted start.
REQ-011 cout  output  1  final carry-out; held stable with sum.

Function
REQ-012 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 Transition IDLE->SHIFT on an edge with start=1; a, b and cin are captured into shift and carry registers, and the bit counter is set to 0.
REQ-014 In SHIFT, each edge SHALL add bit 0 of the A and B shift registers and the carry register through one full-adder cell, LSB first.
REQ-015 On each SHIFT edge: the cell sum shifts into the MSB of the result register (shift right), A and B shift right, the carry register takes the cell carry, and the counter increments.
REQ-016 Transition SHIFT->DONE on the edge that processes bit WIDTH-1; on that edge the result register holds the full sum and cout takes the final carry.
REQ-017 The DONE state SHALL last exactly one cycle, with done=1 and busy=0; DONE goes to SHIFT if start=1 on that edge, otherwise to IDLE.
REQ-018 Latency: if start is accepted on edge N, done SHALL be high in the cycle after edge N+WIDTH.
REQ-019 busy SHALL be high exactly in the SHIFT state.
REQ-020 start SHALL be ignored while in SHIFT; the captured operands and the result are unaffected.
REQ-021 start while in IDLE or DONE SHALL be accepted; back-to-back operations are allowed, one every WIDTH+1 cycles.
REQ-022 sum and cout SHALL change only on the SHIFT->DONE edge; they are intermediate-free and do not toggle during SHIFT.
REQ-023 Arithmetic: {cout,sum} SHALL equal a+b+cin, computed modulo 2^(WIDTH+1).
REQ-024 Counter width SHALL be clog2(WIDTH) bits, minimum 1 bit; with WIDTH=1, SHIFT lasts one cycle.

Reset
REQ-025 While rst=1: state=IDLE, busy=0, done=0, sum=0, cout=0, and counter, carry and shift registers are cleared, regardless of the clock.
REQ-026 Reset asserted during SHIFT SHALL abort the operation, and no done pulse SHALL follow.
REQ-027 The first start is accepted on the first rising edge after rst deasserts.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the state enumeration (IDLE, SHIFT, DONE) and the WIDTH default constant.
REQ-029 One sub-module SHALL be used: full_adder_cell (a, b, cin -> s, co), purely combinational, built from two half-adder stages; it is instantiated exactly once.
REQ-030 There SHALL be no combinational path from inputs to outputs; all outputs are registered.

Verification (WIDTH=8)
REQ-031 Start with a=0x0F, b=0x01, cin=0 -> done 8 cycles after the accepting edge; sum=0x10, cout=0; busy high for exactly 8 cycles.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple); a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-033 Start held high through SHIFT with a changed to 0x55 mid-operation -> result reflects the original operands; exactly one done pulse.
REQ-034 rst pulsed at SHIFT cycle 4 -> all outputs 0 immediately (asynchronous), no done pulse; the next start completes correctly.
REQ-035 Start asserted in the DONE cycle with a=0x01, b=0x02, cin=0 -> second done follows 9 cycles after the first, sum=0x03.
REQ-036 Random regression: 1000 operands with random start gaps -> {cout,sum} matches a+b+cin every time; done is never asserted for more than one cycle.
